// File: rtl/mem_word_assembler_pkg.sv
//------------------------------------------------------------------------------
// mem_word_assembler_pkg : shared state encoding and constants for the assembler
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package mem_word_assembler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [15:0] WORD_ERR    = 16'hFFFF;

    // Little-endian: the even byte address carries bits [7:0].
    localparam logic        LO_BYTE_SEL = 1'b0;
    localparam logic        HI_BYTE_SEL = 1'b1;

    function automatic logic [15:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_word_assembler_if.sv
//------------------------------------------------------------------------------
// mem_word_assembler_if : request/result and byte-memory bus of the assembler
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface mem_word_assembler_if #(
    parameter int ADDR_W = 16
) ();

    logic              req;
    logic [ADDR_W-2:0] word_addr;
    logic              busy;
    logic              done;
    logic [15:0]       word_out;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    // master: control unit + memory side; slave: the assembler itself
    modport master (
        output req, word_addr, mem_rdata, mem_ready,
        input  busy, done, word_out, err, mem_addr, mem_rd
    );

    modport slave (
        input  req, word_addr, mem_rdata, mem_ready,
        output busy, done, word_out, err, mem_addr, mem_rd
    );

endinterface

`default_nettype wire

// File: rtl/mem_word_assembler_wait_timer.sv
//------------------------------------------------------------------------------
// mem_word_assembler_wait_timer : wait-cycle counter with clear, enable, expiry
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mem_word_assembler_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry fires on the TIMEOUT-th consecutive enabled cycle itself.
    assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_word_assembler.sv
//------------------------------------------------------------------------------
// mem_word_assembler : fetches two bytes and presents a 16-bit little-endian word
// Optional macro WAIT_TIMEOUT_EN adds a per-byte wait timeout with err pulse.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mem_word_assembler
    import mem_word_assembler_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mem_word_assembler_if.slave  bus
);

    state_e            state_q,    state_d;
    logic [ADDR_W-2:0] addr_q,     addr_d;
    logic [7:0]        lo_q,       lo_d;
    logic [15:0]       word_q,     word_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              mem_rd_q,   mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

`ifdef WAIT_TIMEOUT_EN
    logic err_q, err_d;
    logic in_read_w;
    logic timeout_w;

    assign in_read_w = (state_q == RD_LO) || (state_q == RD_HI);

    // Clearing on mem_ready restarts the count for the next byte's state entry.
    mem_word_assembler_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) wait_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_i   (!in_read_w || bus.mem_ready),
        .en_i      (in_read_w && !bus.mem_ready),
        .expired_o (timeout_w)
    );

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        word_d  = word_q;
`ifdef WAIT_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.word_addr;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                if (bus.mem_ready) begin
                    lo_d    = bus.mem_rdata;
                    state_d = RD_HI;
                end
`ifdef WAIT_TIMEOUT_EN
                else if (timeout_w) begin
                    word_d  = WORD_ERR;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            RD_HI: begin
                if (bus.mem_ready) begin
                    word_d  = pack_word(bus.mem_rdata, lo_q);
                    state_d = DONE;
                end
`ifdef WAIT_TIMEOUT_EN
                else if (timeout_w) begin
                    word_d  = WORD_ERR;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        mem_rd_d   = (state_d == RD_LO) || (state_d == RD_HI);
        mem_addr_d = mem_addr_q;
        if (state_d == RD_LO) begin
            mem_addr_d = {addr_d, LO_BYTE_SEL};
        end else if (state_d == RD_HI) begin
            mem_addr_d = {addr_d, HI_BYTE_SEL};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            lo_q       <= '0;
            word_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lo_q       <= lo_d;
            word_q     <= word_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

`ifdef WAIT_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.word_out = word_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_word_assembler.sv
//------------------------------------------------------------------------------
// tb_mem_word_assembler : directed + randomized self-checking bench
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

`define CHK(tag, obs, exp) check(tag, 32'(obs), 32'(exp))

module tb_mem_word_assembler;

    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_word_assembler_if #(.ADDR_W(ADDR_W)) bus ();

    mem_word_assembler #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mem [0:(1<<ADDR_W)-1];
    logic [15:0] last_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((bus.done === 1'b1) && (bus.busy !== 1'b1)) begin
                failures++;
                $error("FAIL mon_done_busy done=%b busy=%b", bus.done, bus.busy);
            end
            checks++;
            if ((bus.mem_rd === 1'b1) && (bus.done !== 1'b0)) begin
                failures++;
                $error("FAIL mon_rd_done mem_rd=%b done=%b", bus.mem_rd, bus.done);
            end
            checks++;
            if ((bus.err === 1'b1) && (bus.done !== 1'b1)) begin
                failures++;
                $error("FAIL mon_err_done err=%b done=%b", bus.err, bus.done);
            end
        end
    end

    function automatic logic [15:0] ref_word(input logic [ADDR_W-2:0] a);
        logic [ADDR_W-1:0] even;
        logic [ADDR_W-1:0] odd;
        even = {a, 1'b0};
        odd  = {a, 1'b1};
        return {mem[odd], mem[even]};
    endfunction

    task automatic check_all_zero(input string tag);
        `CHK({tag, "_busy"},     bus.busy,     0);
        `CHK({tag, "_done"},     bus.done,     0);
        `CHK({tag, "_err"},      bus.err,      0);
        `CHK({tag, "_mem_rd"},   bus.mem_rd,   0);
        `CHK({tag, "_mem_addr"}, bus.mem_addr, 0);
        `CHK({tag, "_word"},     bus.word_out, 0);
    endtask

    // One word read; wl/wh are the wait cycles inserted before each byte.
    task automatic read_word(input logic [ADDR_W-2:0] a, input int wl, input int wh);
        logic [15:0]       exp_w;
        logic [ADDR_W-1:0] ba;
        int                w;
        exp_w = ref_word(a);
        @(negedge clk);
        bus.req       = 1'b1;
        bus.word_addr = a;
        @(negedge clk);
        bus.req       = 1'b0;
        bus.word_addr = (ADDR_W-1)'($urandom);
        for (int ph = 0; ph < 2; ph++) begin
            w  = (ph == 0) ? wl : wh;
            ba = {a, ph[0]};
            for (int i = 0; i <= w; i++) begin
                `CHK("rd_busy",   bus.busy,     1);
                `CHK("rd_strobe", bus.mem_rd,   1);
                `CHK("rd_addr",   bus.mem_addr, ba);
                `CHK("rd_done",   bus.done,     0);
                `CHK("rd_hold",   bus.word_out, last_word);
                bus.mem_ready = (i == w);
                bus.mem_rdata = (i == w) ? mem[ba] : 8'($urandom);
                @(negedge clk);
            end
        end
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = 8'($urandom);
        `CHK("done_pulse",  bus.done,     1);
        `CHK("done_word",   bus.word_out, exp_w);
        `CHK("done_err",    bus.err,      0);
        `CHK("done_busy",   bus.busy,     1);
        `CHK("done_strobe", bus.mem_rd,   0);
        last_word = exp_w;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        `CHK("idle_done", bus.done,     0);
        `CHK("idle_busy", bus.busy,     0);
        `CHK("idle_word", bus.word_out, last_word);
    endtask

    task automatic streaming_reqs(input int n);
        logic [ADDR_W-2:0] a;
        logic [ADDR_W-2:0] next_a;
        @(negedge clk);
        a             = (ADDR_W-1)'($urandom);
        bus.req       = 1'b1;
        bus.word_addr = a;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            next_a = (ADDR_W-1)'($urandom);
            @(negedge clk);
            `CHK("st_lo_addr", bus.mem_addr, {a, 1'b0});
            `CHK("st_lo_done", bus.done,     0);
            `CHK("st_lo_word", bus.word_out, last_word);
            bus.mem_rdata = mem[{a, 1'b0}];
            bus.word_addr = (ADDR_W-1)'($urandom);
            @(negedge clk);
            `CHK("st_hi_addr", bus.mem_addr, {a, 1'b1});
            `CHK("st_hi_done", bus.done,     0);
            bus.mem_rdata = mem[{a, 1'b1}];
            @(negedge clk);
            `CHK("st_done",      bus.done,     1);
            `CHK("st_done_word", bus.word_out, ref_word(a));
            last_word     = ref_word(a);
            bus.word_addr = (ADDR_W-1)'($urandom);
            @(negedge clk);
            `CHK("st_idle_busy", bus.busy,     0);
            `CHK("st_idle_done", bus.done,     0);
            `CHK("st_idle_word", bus.word_out, last_word);
            bus.word_addr = next_a;
            a             = next_a;
            if (k == n - 1) bus.req = 1'b0;
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        `CHK("st_end_busy", bus.busy, 0);
    endtask

    initial begin
        logic [ADDR_W-2:0] a;
        bus.req       = 1'b0;
        bus.word_addr = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        last_word     = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        mem[16'h0020] = 8'h34;
        mem[16'h0021] = 8'h12;
        read_word(15'h0010, 0, 0);
        `CHK("zw_value", last_word, 16'h1234);

        read_word(15'h0123, 3, 3);

        mem[16'hFFFE] = 8'hCD;
        mem[16'hFFFF] = 8'hAB;
        read_word(15'h7FFF, 1, 0);
        `CHK("max_value", last_word, 16'hABCD);

        repeat (10) read_word((ADDR_W-1)'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        streaming_reqs(6);

        // Asynchronous reset while the high byte is outstanding.
        a = (ADDR_W-1)'($urandom);
        @(negedge clk);
        bus.req       = 1'b1;
        bus.word_addr = a;
        @(negedge clk);
        bus.req       = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem[{a, 1'b0}];
        @(negedge clk);
        bus.mem_ready = 1'b0;
        `CHK("mid_rd_hi_addr", bus.mem_addr, {a, 1'b1});
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n     = 1'b1;
        last_word = '0;
        @(negedge clk);
        `CHK("post_rst_busy", bus.busy, 0);
        `CHK("post_rst_rd",   bus.mem_rd, 0);
        read_word((ADDR_W-1)'($urandom), 0, 2);

        // Memory never answers the low byte.
        a = (ADDR_W-1)'($urandom);
        @(negedge clk);
        bus.req       = 1'b1;
        bus.word_addr = a;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.req = 1'b0;
`ifdef WAIT_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT; i++) begin
            `CHK("to_wait_busy", bus.busy,     1);
            `CHK("to_wait_done", bus.done,     0);
            `CHK("to_wait_err",  bus.err,      0);
            `CHK("to_wait_addr", bus.mem_addr, {a, 1'b0});
            @(negedge clk);
        end
        `CHK("to_done",   bus.done,     1);
        `CHK("to_err",    bus.err,      1);
        `CHK("to_word",   bus.word_out, 16'hFFFF);
        `CHK("to_strobe", bus.mem_rd,   0);
        last_word = 16'hFFFF;
        @(negedge clk);
        `CHK("to_idle_done", bus.done,     0);
        `CHK("to_idle_err",  bus.err,      0);
        `CHK("to_idle_busy", bus.busy,     0);
        `CHK("to_idle_word", bus.word_out, 16'hFFFF);
        read_word((ADDR_W-1)'($urandom), 2, 1);
`else
        for (int i = 0; i < 40; i++) begin
            `CHK("nto_busy", bus.busy, 1);
            `CHK("nto_err",  bus.err,  0);
            `CHK("nto_done", bus.done, 0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        last_word = '0;
        read_word((ADDR_W-1)'($urandom), 2, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`undef CHK
`default_nettype wire
